// File: rtl/conv_pkg.sv
// Shared types and size helpers for the convolution window sequencer.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FULL_FETCH,
    COL_FETCH,
    DRAIN,
    PRESENT,
    DONE
  } seq_state_t;

  function automatic int unsigned calc_out(input int unsigned size, input int unsigned ksize);
    return size - ksize + 1;
  endfunction

  function automatic int unsigned calc_addr_w(input int unsigned size);
    return (size * size <= 2) ? 1 : $clog2(size * size);
  endfunction

  function automatic int unsigned calc_idx_w(input int unsigned out);
    return (out <= 2) ? 1 : $clog2(out);
  endfunction

  // Row-major pixel address inside the image memory.
  function automatic int unsigned pixel_addr(input int unsigned row, input int unsigned col,
                                             input int unsigned size);
    return row * size + col;
  endfunction

endpackage

// File: rtl/conv_window_sequencer_pos.sv
// Output-position counter: row-major walk over OUT x OUT window positions.
module win_pos_counter #(
  parameter int unsigned OUT   = 5,
  parameter int unsigned IDX_W = 3
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             i_clear,
  input  logic             i_step,
  output logic [IDX_W-1:0] o_row,
  output logic [IDX_W-1:0] o_col,
  output logic             o_last_col_c,
  output logic             o_last_pos_c
);

  logic [IDX_W-1:0] r_row;
  logic [IDX_W-1:0] r_col;

  always_comb begin
    o_row        = r_row;
    o_col        = r_col;
    o_last_col_c = (r_col == IDX_W'(OUT - 1));
    o_last_pos_c = o_last_col_c && (r_row == IDX_W'(OUT - 1));
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clear) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_step) begin
      if (o_last_col_c) begin
        r_row <= r_row + IDX_W'(1);
        r_col <= '0;
      end else begin
        r_col <= r_col + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/conv_window_sequencer.sv
// Fetches KSIZE x KSIZE pixel windows from a sync memory and hands them to the
// conv datapath over valid/ready; horizontal slides fetch only the new column.
module conv_window_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned SIZE      = 7,
  parameter int unsigned KSIZE     = 3,
  parameter int unsigned WIDTH_BIT = 8,
  localparam int unsigned OUT      = calc_out(SIZE, KSIZE),
  localparam int unsigned ADDR_W   = calc_addr_w(SIZE),
  localparam int unsigned IDX_W    = calc_idx_w(OUT)
) (
  input  logic                             clock,
  input  logic                             nreset,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic                             rd_en,
  output logic [ADDR_W-1:0]                rd_addr,
  input  logic [WIDTH_BIT-1:0]             rd_data,
  output logic                             win_valid,
  input  logic                             win_ready,
  output logic [KSIZE*KSIZE*WIDTH_BIT-1:0] win_data,
  output logic [IDX_W-1:0]                 win_row,
  output logic [IDX_W-1:0]                 win_col
);

  localparam int unsigned NWIN   = KSIZE * KSIZE;
  localparam int unsigned SLOT_W = (NWIN <= 2) ? 1 : $clog2(NWIN);
  localparam int unsigned OFF_W  = (KSIZE <= 2) ? 1 : $clog2(KSIZE);

  seq_state_t           r_state;
  logic                 r_busy, r_done, r_rd_en, r_win_valid, r_last_issued, r_cap_en;
  logic [ADDR_W-1:0]    r_rd_addr;
  logic [SLOT_W-1:0]    r_rd_slot, r_cap_slot;
  logic [OFF_W-1:0]     r_fr, r_fc;
  logic [WIDTH_BIT-1:0] r_win [NWIN];

  logic [IDX_W-1:0]  w_row, w_col, w_base_row, w_base_col;
  logic              w_last_col, w_last_pos;
  logic              w_hs, w_slide, w_row_chg, w_start, w_launch, w_col_mode, w_issue, w_last_issue;
  logic [OFF_W-1:0]  w_off_r, w_off_c, w_nfr, w_nfc;
  logic [ADDR_W-1:0] w_addr;
  logic [SLOT_W-1:0] w_slot;

  win_pos_counter #(.OUT(OUT), .IDX_W(IDX_W)) u_pos (
    .clock        (clock),
    .nreset       (nreset),
    .i_clear      (w_start),
    .i_step       (w_slide || w_row_chg),
    .o_row        (w_row),
    .o_col        (w_col),
    .o_last_col_c (w_last_col),
    .o_last_pos_c (w_last_pos)
  );

  // Launch edges issue their first read using the position the counter is about to take.
  always_comb begin
    w_hs       = (r_state == PRESENT) && win_ready;
    w_slide    = w_hs && !w_last_col;
    w_row_chg  = w_hs && w_last_col && !w_last_pos;
    w_start    = (r_state == IDLE) && start;
    w_launch   = w_start || w_slide || w_row_chg;
    w_col_mode = w_launch ? w_slide : (r_state == COL_FETCH);
    w_issue    = w_launch ||
                 (((r_state == FULL_FETCH) || (r_state == COL_FETCH)) && !r_last_issued);
    w_off_r    = w_launch ? '0 : r_fr;
    w_off_c    = w_launch ? (w_slide ? OFF_W'(KSIZE - 1) : '0) : r_fc;
    w_base_row = w_row;
    w_base_col = w_col;
    if (r_state == IDLE) begin
      w_base_row = '0;
      w_base_col = '0;
    end else if (w_row_chg) begin
      w_base_row = w_row + IDX_W'(1);
      w_base_col = '0;
    end else if (w_slide) begin
      w_base_col = w_col + IDX_W'(1);
    end
    w_last_issue = (w_off_r == OFF_W'(KSIZE - 1)) &&
                   (w_col_mode || (w_off_c == OFF_W'(KSIZE - 1)));
    if (w_col_mode || (w_off_c == OFF_W'(KSIZE - 1))) begin
      w_nfr = w_off_r + OFF_W'(1);
      w_nfc = w_col_mode ? OFF_W'(KSIZE - 1) : '0;
    end else begin
      w_nfr = w_off_r;
      w_nfc = w_off_c + OFF_W'(1);
    end
    w_addr = ADDR_W'(pixel_addr(32'(w_base_row) + 32'(w_off_r),
                                32'(w_base_col) + 32'(w_off_c), SIZE));
    w_slot = SLOT_W'(32'(w_off_r) * KSIZE + 32'(w_off_c));
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state       <= IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_rd_en       <= 1'b0;
      r_rd_addr     <= '0;
      r_rd_slot     <= '0;
      r_cap_en      <= 1'b0;
      r_cap_slot    <= '0;
      r_fr          <= '0;
      r_fc          <= '0;
      r_last_issued <= 1'b0;
      r_win_valid   <= 1'b0;
      for (int unsigned i = 0; i < NWIN; i++) r_win[SLOT_W'(i)] <= '0;
    end else begin
      // Read data lands one cycle after the strobe; the slot tag follows it.
      r_cap_en   <= r_rd_en;
      r_cap_slot <= r_rd_slot;
      if (r_cap_en) r_win[r_cap_slot] <= rd_data;

      if (w_issue) begin
        r_rd_en       <= 1'b1;
        r_rd_addr     <= w_addr;
        r_rd_slot     <= w_slot;
        r_fr          <= w_nfr;
        r_fc          <= w_nfc;
        r_last_issued <= w_last_issue;
      end else begin
        r_rd_en   <= 1'b0;
        r_rd_addr <= '0;
      end

      if (w_slide) begin
        for (int unsigned r = 0; r < KSIZE; r++)
          for (int unsigned c = 0; c + 1 < KSIZE; c++)
            r_win[SLOT_W'(r * KSIZE + c)] <= r_win[SLOT_W'(r * KSIZE + c + 1)];
      end

      case (r_state)
        IDLE: if (start) begin
          r_state <= FULL_FETCH;
          r_busy  <= 1'b1;
        end
        FULL_FETCH, COL_FETCH: if (r_last_issued) r_state <= DRAIN;
        DRAIN: begin
          r_state     <= PRESENT;
          r_win_valid <= 1'b1;
        end
        PRESENT: if (win_ready) begin
          r_win_valid <= 1'b0;
          if (w_last_pos) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else if (w_last_col) begin
            r_state <= FULL_FETCH;
          end else begin
            r_state <= COL_FETCH;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = r_busy;
    done      = r_done;
    rd_en     = r_rd_en;
    rd_addr   = r_rd_addr;
    win_valid = r_win_valid;
    win_row   = w_row;
    win_col   = w_col;
    win_data  = '0;
    for (int unsigned i = 0; i < NWIN; i++)
      win_data[i*WIDTH_BIT +: WIDTH_BIT] = r_win[SLOT_W'(i)];
  end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed bench for conv_window_sequencer on a 7x7 image with pixel(r,c) = r*7+c.
module tb_conv_window_sequencer;

  logic        clock = 1'b0;
  logic        nreset = 1'b1;
  logic        start = 1'b0;
  logic        win_ready = 1'b0;
  logic        busy, done, rd_en, win_valid;
  logic [5:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [71:0] win_data;
  logic [2:0]  win_row, win_col;

  int n_cmp = 0;
  int n_bad = 0;
  int rd_log[$];
  int hs_cnt = 0;
  int done_cnt = 0;
  int last_hs_row, last_hs_col;
  logic [71:0] last_hs_data;

  conv_window_sequencer dut (
    .clock     (clock),
    .nreset    (nreset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_data  (win_data),
    .win_row   (win_row),
    .win_col   (win_col)
  );

  always #5 clock = ~clock;

  // Pixel memory: value equals its address for this image.
  always @(posedge clock) begin
    if (rd_en) begin
      rd_data <= 8'(rd_addr);
      rd_log.push_back(int'(rd_addr));
    end
  end

  always @(posedge clock) begin
    if (nreset && win_valid && win_ready) begin
      hs_cnt++;
      last_hs_data = win_data;
      last_hs_row  = int'(win_row);
      last_hs_col  = int'(win_col);
    end
    if (done) done_cnt++;
  end

  function automatic logic [71:0] pk(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
    return {8'(e8), 8'(e7), 8'(e6), 8'(e5), 8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_valid(output int n, input int limit);
    n = 0;
    do begin
      step();
      n++;
    end while (!win_valid && n < limit);
  endtask

  task automatic test_reset();
    #1 nreset = 1'b0;
    step();
    n_cmp++; if ({busy, done, rd_en, win_valid} !== 4'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 0000", {busy, done, rd_en, win_valid});
    end
    n_cmp++; if (rd_addr !== 6'd0) begin
      n_bad++; $display("FAIL reset_addr: got %0d want 0", rd_addr);
    end
    n_cmp++; if (win_data !== 72'd0) begin
      n_bad++; $display("FAIL reset_data: got %h want 0", win_data);
    end
    n_cmp++; if ({win_row, win_col} !== 6'd0) begin
      n_bad++; $display("FAIL reset_pos: got %0d,%0d want 0,0", win_row, win_col);
    end
    nreset = 1'b1;
    step();
  endtask

  task automatic test_first_window();
    int n;
    int exp_rd[9] = '{0, 1, 2, 7, 8, 9, 14, 15, 16};
    bit ok;
    win_ready = 1'b1;
    rd_log.delete();
    pulse_start();
    n_cmp++; if (busy !== 1'b1) begin
      n_bad++; $display("FAIL first_busy: got %b want 1", busy);
    end
    wait_valid(n, 40);
    n_cmp++; if (n != 10 || win_valid !== 1'b1) begin
      n_bad++; $display("FAIL first_latency: got %0d valid=%b want 10 valid=1", n, win_valid);
    end
    n_cmp++; if (win_data !== pk(0, 1, 2, 7, 8, 9, 14, 15, 16)) begin
      n_bad++; $display("FAIL first_data: got %h want %h", win_data, pk(0, 1, 2, 7, 8, 9, 14, 15, 16));
    end
    n_cmp++; if (win_row !== 3'd0 || win_col !== 3'd0) begin
      n_bad++; $display("FAIL first_pos: got %0d,%0d want 0,0", win_row, win_col);
    end
    ok = (rd_log.size() == 9);
    if (ok) foreach (exp_rd[i]) if (rd_log[i] != exp_rd[i]) ok = 0;
    n_cmp++; if (!ok) begin
      n_bad++; $display("FAIL first_reads: got %p want %p", rd_log, exp_rd);
    end
  endtask

  task automatic test_slide();
    int n;
    int exp_rd[3] = '{3, 10, 17};
    bit ok;
    rd_log.delete();
    wait_valid(n, 40);
    n_cmp++; if (n != 5 || win_valid !== 1'b1) begin
      n_bad++; $display("FAIL slide_latency: got %0d valid=%b want 5 valid=1", n, win_valid);
    end
    ok = (rd_log.size() == 3);
    if (ok) foreach (exp_rd[i]) if (rd_log[i] != exp_rd[i]) ok = 0;
    n_cmp++; if (!ok) begin
      n_bad++; $display("FAIL slide_reads: got %p want %p", rd_log, exp_rd);
    end
    n_cmp++; if (win_data !== pk(1, 2, 3, 8, 9, 10, 15, 16, 17)) begin
      n_bad++; $display("FAIL slide_data: got %h want %h", win_data, pk(1, 2, 3, 8, 9, 10, 15, 16, 17));
    end
    n_cmp++; if (win_row !== 3'd0 || win_col !== 3'd1) begin
      n_bad++; $display("FAIL slide_pos: got %0d,%0d want 0,1", win_row, win_col);
    end
  endtask

  task automatic test_row_change();
    int n;
    int exp_rd[9] = '{7, 8, 9, 14, 15, 16, 21, 22, 23};
    bit ok;
    repeat (3) wait_valid(n, 40);
    n_cmp++; if (win_row !== 3'd0 || win_col !== 3'd4) begin
      n_bad++; $display("FAIL row_end_pos: got %0d,%0d want 0,4", win_row, win_col);
    end
    rd_log.delete();
    wait_valid(n, 40);
    n_cmp++; if (n != 11 || win_valid !== 1'b1) begin
      n_bad++; $display("FAIL rowchg_latency: got %0d valid=%b want 11 valid=1", n, win_valid);
    end
    ok = (rd_log.size() == 9);
    if (ok) foreach (exp_rd[i]) if (rd_log[i] != exp_rd[i]) ok = 0;
    n_cmp++; if (!ok) begin
      n_bad++; $display("FAIL rowchg_reads: got %p want %p", rd_log, exp_rd);
    end
    n_cmp++; if (win_data !== pk(7, 8, 9, 14, 15, 16, 21, 22, 23)) begin
      n_bad++; $display("FAIL rowchg_data: got %h want %h", win_data, pk(7, 8, 9, 14, 15, 16, 21, 22, 23));
    end
    n_cmp++; if (win_row !== 3'd1 || win_col !== 3'd0) begin
      n_bad++; $display("FAIL rowchg_pos: got %0d,%0d want 1,0", win_row, win_col);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int hs0;
    int guard;
    logic [71:0] exp_w;
    exp_w = pk(17, 18, 19, 24, 25, 26, 31, 32, 33);
    guard = 0;
    while (!(win_row == 3'd2 && win_col == 3'd3) && guard < 20) begin
      wait_valid(n, 40);
      guard++;
    end
    n_cmp++; if (win_row !== 3'd2 || win_col !== 3'd3 || win_valid !== 1'b1) begin
      n_bad++; $display("FAIL bp_reach: got %0d,%0d valid=%b want 2,3 valid=1", win_row, win_col, win_valid);
    end
    win_ready = 1'b0;
    hs0 = hs_cnt;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (win_valid !== 1'b1 || rd_en !== 1'b0 || win_data !== exp_w ||
          win_row !== 3'd2 || win_col !== 3'd3) begin
        n_bad++;
        $display("FAIL bp_hold%0d: got v=%b rd=%b %h @%0d,%0d want v=1 rd=0 %h @2,3",
                 i, win_valid, rd_en, win_data, win_row, win_col, exp_w);
      end
    end
    win_ready = 1'b1;
    step();
    n_cmp++; if (hs_cnt != hs0 + 1 || win_valid !== 1'b0) begin
      n_bad++; $display("FAIL bp_release: got hs=%0d valid=%b want hs=%0d valid=0", hs_cnt - hs0, win_valid, 1);
    end
    guard = 0;
    while (!win_valid && guard < 20) begin step(); guard++; end
    n_cmp++; if (win_row !== 3'd2 || win_col !== 3'd4) begin
      n_bad++; $display("FAIL bp_next_pos: got %0d,%0d want 2,4", win_row, win_col);
    end
    guard = 0;
    while (!done && guard < 400) begin step(); guard++; end
    step();
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL bp_pass_end: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_full_pass();
    int done_edge;
    int done_hi;
    hs_cnt = 0;
    done_edge = -1;
    done_hi = 0;
    win_ready = 1'b1;
    pulse_start();
    for (int i = 1; i <= 170; i++) begin
      start = (i == 49);
      step();
      if (done) begin
        if (done_edge < 0) done_edge = i;
        done_hi++;
      end
    end
    start = 1'b0;
    n_cmp++; if (hs_cnt != 25) begin
      n_bad++; $display("FAIL full_handshakes: got %0d want 25", hs_cnt);
    end
    n_cmp++; if (last_hs_data !== pk(32, 33, 34, 39, 40, 41, 46, 47, 48) ||
                 last_hs_row != 4 || last_hs_col != 4) begin
      n_bad++; $display("FAIL full_last_win: got %h @%0d,%0d want %h @4,4", last_hs_data,
                        last_hs_row, last_hs_col, pk(32, 33, 34, 39, 40, 41, 46, 47, 48));
    end
    n_cmp++; if (done_edge != 155 || done_hi != 1) begin
      n_bad++; $display("FAIL full_done: got edge %0d cycles %0d want edge 155 cycles 1", done_edge, done_hi);
    end
    n_cmp++; if (busy !== 1'b0) begin
      n_bad++; $display("FAIL full_busy_after: got %b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int done0;
    done0 = done_cnt;
    win_ready = 1'b1;
    pulse_start();
    repeat (4) step();
    nreset = 1'b0;
    #1;
    n_cmp++; if ({busy, done, rd_en, win_valid} !== 4'b0 || rd_addr !== 6'd0 ||
                 win_data !== 72'd0 || {win_row, win_col} !== 6'd0) begin
      n_bad++; $display("FAIL midreset_outputs: got %b addr=%0d data=%h pos=%0d,%0d want all 0",
                        {busy, done, rd_en, win_valid}, rd_addr, win_data, win_row, win_col);
    end
    step();
    nreset = 1'b1;
    repeat (12) step();
    n_cmp++; if (done_cnt != done0 || win_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL midreset_idle: got done=%0d valid=%b busy=%b want 0 0 0",
                        done_cnt - done0, win_valid, busy);
    end
    pulse_start();
    wait_valid(n, 40);
    n_cmp++; if (n != 10 || win_data !== pk(0, 1, 2, 7, 8, 9, 14, 15, 16) ||
                 win_row !== 3'd0 || win_col !== 3'd0) begin
      n_bad++; $display("FAIL restart_first: got lat=%0d %h @%0d,%0d want lat=10 %h @0,0",
                        n, win_data, win_row, win_col, pk(0, 1, 2, 7, 8, 9, 14, 15, 16));
    end
  endtask

  initial begin
    test_reset();
    test_first_window();
    test_slide();
    test_row_change();
    test_backpressure();
    test_full_pass();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_window_sequencer.md
Name: conv_window_sequencer

Overview:
Sequences the 3x3 convolution datapath across a SIZE x SIZE input image held in a synchronous single-port pixel memory. It fetches pixels, assembles each KSIZE x KSIZE window in registers and presents it to the conv datapath over a valid/ready handshake, stepping row-major through all output positions. Horizontal slides reuse the two overlapping window columns and fetch only the new column. This replaces free-running index generation with a controlled, backpressure-aware schedule.

Parameters:
SIZE, 7, image edge length in pixels
KSIZE, 3, kernel/window edge length
WIDTH_BIT, 8, pixel width in bits
(localparams: OUT = SIZE-KSIZE+1; ADDR_W = $clog2(SIZE*SIZE); IDX_W = $clog2(OUT), minimum 1)

Ports:
clock  in  1  single clock, rising edge
nreset  in  1  asynchronous, active-low reset
start  in  1  pulse; begins a full image pass when idle
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse after the final window handshake
rd_en  out  1  pixel memory read strobe
rd_addr  out  ADDR_W  pixel address = row*SIZE + col
rd_data  in  WIDTH_BIT  read data, valid exactly 1 cycle after rd_en
win_valid  out  1  window registers hold a complete window
win_ready  in  1  conv datapath accepts the window
win_data  out  KSIZE*KSIZE*WIDTH_BIT  element (r,c) at [(r*KSIZE+c)*WIDTH_BIT +: WIDTH_BIT]
win_row  out  IDX_W  output row index of presented window
win_col  out  IDX_W  output column index of presented window

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low (nreset). While nreset is low, every output is 0, the FSM is IDLE and the window registers are 0. Asserting reset mid-pass abandons the pass; no done pulse.
- FSM states:
  - IDLE: start=1 -> FULL_FETCH with position (0,0); busy=1.
  - FULL_FETCH: issue KSIZE*KSIZE reads on consecutive cycles, row-major within the window, then -> DRAIN.
  - COL_FETCH: issue KSIZE reads for column win_col+KSIZE-1, rows top to bottom, then -> DRAIN.
  - DRAIN: capture the last read -> PRESENT.
  - PRESENT: win_valid=1.
  - DONE: done=1 for one cycle -> IDLE.
- Read data is captured one cycle after its rd_en. On a column slide, all window columns shift left by one before the new column is written in.
- Handshake and stepping: the handshake occurs on the edge where win_valid & win_ready. Then:
  - col < OUT-1: col+1, go to COL_FETCH.
  - col = OUT-1, row < OUT-1: col=0, row+1, go to FULL_FETCH.
  - last window: go to DONE.
- Latency, edge 0 = start sampled: win_valid rises after edge 10 (9 reads at edges 1..9). After a handshake at edge h, a slide gives win_valid after h+4; a row change gives win_valid after h+10.
- Backpressure: while win_valid=1 and win_ready=0, win_data, win_row and win_col hold stable, rd_en=0 and no state change occurs.
- win_ready while win_valid=0 is ignored. start while busy is ignored.
- rd_en=0 outside the fetch states; rd_addr is a don't-care when rd_en=0 but is driven 0.
- No arithmetic overflow: addresses are bounded by SIZE*SIZE-1.

Decomposition:
- Package conv_pkg:
  - seq_state_t enum {IDLE, FULL_FETCH, COL_FETCH, DRAIN, PRESENT, DONE}
  - localparam functions for OUT, ADDR_W and IDX_W
  - the pixel address function row*SIZE+col
- One natural sub-module, win_pos_counter: row/col output-position counter with step/clear inputs and last_col/last_pos flags.
- Fetch sequencing, shift logic and the FSM stay in conv_window_sequencer.

Test Plan:
- Image pixel(r,c)=r*7+c, start at edge 0, win_ready=1 -> win_valid after edge 10; win_data = 0,1,2,7,8,9,14,15,16; win_row=0, win_col=0.
- Next window (0,1) -> only 3 reads, addresses 3,10,17; win_data = 1,2,3,8,9,10,15,16,17; valid 4 cycles after handshake.
- Row change to (1,0) -> 9 reads, addresses 7,8,9,14,15,16,21,22,23; valid 10 cycles after handshake.
- Hold win_ready=0 for 5 cycles on window (2,3) -> win_data = 17,18,19,24,25,26,31,32,33 stable throughout, rd_en=0, single handshake when released.
- Full pass with ready=1 -> exactly 25 handshakes; last window (4,4) = 32,33,34,39,40,41,46,47,48; done high for the single cycle after edge 155; busy low afterwards.
- Assert nreset low during cycle 5 of the first fetch -> all outputs 0 immediately, no done. Then start -> pass restarts at (0,0) with the same first window. A start pulsed mid-pass has no effect.
